insn_prefetch_queue: RTL

Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the instruction memory port.
- Buffers fetched {pc, insn} pairs in a small FIFO.
- Presents them to decode with a valid/ready handshake; ready is the pipeline's inverted stall.
- A redirect input flushes all buffered and in-flight fetches and restarts at a new PC.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/insn_prefetch_queue_if.sv | 30 +++
 rtl/insn_prefetch_queue_fetch_fifo.sv | 53 +++++
 rtl/insn_prefetch_queue.sv | 89 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word size, NOP encoding, PC step and the
// {pc, insn} record carried through the fetch queue.
package cpu_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(PC_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/insn_prefetch_queue_if.sv
// Fetch-unit bus: instruction memory port, decode handshake and redirect.
interface insn_prefetch_queue_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_insn;

    // Decode handshake: a transfer happens in any cycle where out_valid and
    // out_ready are both 1; while out_valid=1 and out_ready=0 the presented
    // out_pc/out_insn stay stable. out_ready is the pipeline's inverted stall.
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_insn;
    logic [XLEN-1:0] out_pc;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_insn, out_pc,
        input  imem_insn, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_insn, out_pc,
        output imem_insn, out_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/insn_prefetch_queue_fetch_fifo.sv
// DEPTH-entry {pc, insn} FIFO with flush; head is read combinationally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Flush wins over push and pop; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (i_pop && !i_push) r_count <= r_count - 1'b1;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_count <= DEPTH_C);

endmodule

// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch front-end: owns the fetch PC, buffers {pc, insn} pairs
// for decode, flushes on redirect. PREFETCH_BYPASS_EN adds a response-to-decode bypass.
module insn_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    insn_prefetch_queue_if.master  fe,
    output logic [$clog2(DEPTH):0] o_occupancy
);
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_inflight_pc;
    logic [XLEN-1:0] r_last_pc;
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_level;
    fetch_entry_t    w_head;
    fetch_entry_t    w_resp;
    fetch_entry_t    w_out;
    logic            w_resp_valid;
    logic            w_bypass;
    logic            w_out_valid;
    logic            w_pop;
    logic            w_fifo_pop;
    logic            w_push;
    logic            w_issue;

    assign w_resp       = '{pc: r_inflight_pc, insn: fe.imem_insn};
    assign w_resp_valid = r_inflight & ~fe.redirect_valid;

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = w_resp_valid & (w_count == '0);
    assign w_out    = w_bypass ? w_resp : w_head;
`else
    assign w_bypass = 1'b0;
    assign w_out    = w_head;
`endif

    // A redirect hides the head so nothing stale can be consumed in that cycle.
    assign w_out_valid = ~fe.redirect_valid & ((w_count != '0) | w_bypass);
    assign w_pop       = w_out_valid & fe.out_ready;
    assign w_fifo_pop  = w_pop & ~w_bypass;
    assign w_push      = w_resp_valid & ~(w_bypass & fe.out_ready);

    // Slots committed after this cycle: buffered + arriving - leaving.
    assign w_level = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
    assign w_issue = rst_n & ~fe.redirect_valid & (w_level < LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_last_pc     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            if (fe.redirect_valid) r_fetch_pc <= align_pc(fe.redirect_pc);
            else if (w_issue)      r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (w_out_valid) r_last_pc <= w_out.pc;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_fifo_pop),
        .i_flush (fe.redirect_valid),
        .i_data  (w_resp),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign fe.imem_req  = w_issue;
    assign fe.imem_addr = r_fetch_pc;
    assign fe.out_valid = w_out_valid;
    assign fe.out_insn  = w_out_valid ? w_out.insn : NOP_INSN;
    assign fe.out_pc    = w_out_valid ? w_out.pc : r_last_pc;
    assign o_occupancy  = w_count;

endmodule
